// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants, FSM state type and address helper for the NTT layer sequencer
package ntt_pkg;

    localparam int N          = 256;
    localparam int LOGN       = 8;
    localparam int Q          = 3329;
    localparam int NUM_LAYERS = 7;
    localparam int MEM_LAT    = 1;
    localparam int PE_LAT     = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    typedef struct packed {
        logic [LOGN-1:0] addr_u;
        logic [LOGN-1:0] addr_v;
        logic [LOGN-2:0] tw;
    } issue_t;

    // Butterfly k of a layer: pair addresses and twiddle index.
    // sh is log2(len); the group index g selects the twiddle, o is the offset in the group.
    function automatic issue_t calc_issue(input logic [LOGN-2:0] k,
                                          input logic [2:0]      layer,
                                          input logic            mode);
        issue_t          r;
        logic [3:0]      sh;
        logic [LOGN-1:0] len;
        logic [LOGN-1:0] g;
        logic [LOGN-1:0] o;
        logic [LOGN-1:0] u;
        logic [LOGN-1:0] t;
        sh  = mode ? ({1'b0, layer} + 4'd1) : (4'd7 - {1'b0, layer});
        len = LOGN'(1) << sh;
        g   = {1'b0, k} >> sh;
        o   = {1'b0, k} & (len - LOGN'(1));
        u   = (g << (sh + 4'd1)) | o;
        t   = mode ? ((LOGN'(N/2) >> layer) - LOGN'(1) - g)
                   : ((LOGN'(1) << layer) + g);
        r.addr_u = u;
        r.addr_v = u + len;
        r.tw     = t[LOGN-2:0];
        return r;
    endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// rtl/ntt_delay_line.sv - fixed-depth shift register carrying a valid bit and a data word
module ntt_delay_line #(
    parameter int DEPTH = 7,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [DEPTH-1:0] o_valid_vec
);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];

    // Shift every stage by one each cycle; bubbles travel as valid=0 entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign o_valid     = r_valid[DEPTH-1];
    assign o_data      = r_data[DEPTH-1];
    assign o_valid_vec = r_valid;

endmodule

// File: rtl/ntt_layer_issue.sv
// rtl/ntt_layer_issue.sv - walks one NTT/INTT layer, issuing pair reads and aligned write-backs
module ntt_layer_issue
    import ntt_pkg::*;
#(
    parameter int N       = ntt_pkg::N,
    parameter int ADDR_W  = ntt_pkg::LOGN,
    parameter int TW_W    = ntt_pkg::LOGN - 1,
    parameter int MEM_LAT = ntt_pkg::MEM_LAT,
    parameter int PE_LAT  = ntt_pkg::PE_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [2:0]        layer,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              pe_sel,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_u,
    output logic [ADDR_W-1:0] rd_addr_v,
    output logic [TW_W-1:0]   tw_idx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr_u,
    output logic [ADDR_W-1:0] wr_addr_v
);

    localparam int DEPTH  = MEM_LAT + PE_LAT;
    localparam int K_LAST = N/2 - 1;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-2:0]   r_k;
    logic [2:0]          r_layer;
    logic                r_mode;
    logic [ADDR_W-1:0]   r_rd_addr_u;
    logic [ADDR_W-1:0]   r_rd_addr_v;
    logic [TW_W-1:0]     r_tw;

    logic                w_accept;
    logic                w_issue;
    logic                w_last_k;
    logic                w_line_empty;
    issue_t              w_first;
    issue_t              w_next;
    logic [DEPTH-1:0]    w_valid_vec;
    logic [2*ADDR_W-1:0] w_wr_data;

    assign w_accept = (r_state == IDLE) && start && (layer != 3'd7);
    assign w_issue  = (r_state == ISSUE) && !hold;
    assign w_last_k = (r_k == K_LAST[ADDR_W-2:0]);
    // The output stage leaves on this edge, so only the earlier stages matter.
    assign w_line_empty = ~|w_valid_vec[DEPTH-2:0];

    assign w_first = calc_issue('0, layer, mode);
    assign w_next  = calc_issue(r_k + 1'b1, r_layer, r_mode);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic for the layer walk.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)             w_next_state = ISSUE;
            ISSUE:   if (w_issue && w_last_k)  w_next_state = DRAIN;
            DRAIN:   if (w_line_empty)         w_next_state = FIN;
            FIN:                               w_next_state = IDLE;
            default:                           w_next_state = IDLE;
        endcase
    end

    // Latch the layer on start and precompute the addresses of the butterfly to issue next,
    // so the read outputs are registered and stay put after the final issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k         <= '0;
            r_layer     <= '0;
            r_mode      <= 1'b0;
            r_rd_addr_u <= '0;
            r_rd_addr_v <= '0;
            r_tw        <= '0;
        end else if (w_accept) begin
            r_k         <= '0;
            r_layer     <= layer;
            r_mode      <= mode;
            r_rd_addr_u <= w_first.addr_u;
            r_rd_addr_v <= w_first.addr_v;
            r_tw        <= w_first.tw;
        end else if (w_issue && !w_last_k) begin
            r_k         <= r_k + 1'b1;
            r_rd_addr_u <= w_next.addr_u;
            r_rd_addr_v <= w_next.addr_v;
            r_tw        <= w_next.tw;
        end
    end

    ntt_delay_line #(
        .DEPTH (DEPTH),
        .WIDTH (2*ADDR_W)
    ) u_wr_delay (
        .clk         (clk),
        .rst_n       (rst),
        .i_valid     (w_issue),
        .i_data      ({r_rd_addr_u, r_rd_addr_v}),
        .o_valid     (wr_en),
        .o_data      (w_wr_data),
        .o_valid_vec (w_valid_vec)
    );

    assign wr_addr_u = w_wr_data[2*ADDR_W-1:ADDR_W];
    assign wr_addr_v = w_wr_data[ADDR_W-1:0];
    assign rd_en     = w_issue;
    assign rd_addr_u = r_rd_addr_u;
    assign rd_addr_v = r_rd_addr_v;
    assign tw_idx    = r_tw;
    assign pe_sel    = r_mode;
    assign busy      = (r_state == ISSUE) || (r_state == DRAIN);
    assign done      = (r_state == FIN);

endmodule

// File: tb/tb_ntt_layer_issue.sv
// tb/tb_ntt_layer_issue.sv - scoreboard bench for the NTT layer issue sequencer
module tb_ntt_layer_issue;

    typedef struct {
        int u;
        int v;
        int tw;
    } pair_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       mode;
    logic [2:0] layer;
    logic       hold;
    logic       busy;
    logic       done;
    logic       pe_sel;
    logic       rd_en;
    logic [7:0] rd_addr_u;
    logic [7:0] rd_addr_v;
    logic [6:0] tw_idx;
    logic       wr_en;
    logic [7:0] wr_addr_u;
    logic [7:0] wr_addr_v;

    int n_checks;
    int n_errors;
    pair_t q_rd[$];
    pair_t q_wr[$];

    ntt_layer_issue dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .layer     (layer),
        .hold      (hold),
        .busy      (busy),
        .done      (done),
        .pe_sel    (pe_sel),
        .rd_en     (rd_en),
        .rd_addr_u (rd_addr_u),
        .rd_addr_v (rd_addr_v),
        .tw_idx    (tw_idx),
        .wr_en     (wr_en),
        .wr_addr_u (wr_addr_u),
        .wr_addr_v (wr_addr_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Textbook butterfly loop nest; pushes pairs in issue order.
    task automatic build_model(input logic m, input int l);
        int    len;
        int    grp;
        pair_t p;
        q_rd.delete();
        q_wr.delete();
        len = m ? (2 << l) : (128 >> l);
        grp = 0;
        for (int s = 0; s < 256; s += 2 * len) begin
            for (int j = s; j < s + len; j++) begin
                p.u  = j;
                p.v  = j + len;
                p.tw = m ? ((128 >> l) - 1 - grp) : ((1 << l) + grp);
                q_rd.push_back(p);
                q_wr.push_back(p);
            end
            grp++;
        end
    endtask

    task automatic run_layer(input logic m, input int l, input int hold_k, input int hold_n,
                             input logic poke);
        logic  exp_rd [0:200];
        logic  erd;
        logic  ewr;
        pair_t p;
        build_model(m, l);
        @(posedge clk); #1;
        start = 1'b1; mode = m; layer = 3'(l); hold = 1'b0;
        for (int rel = 1; rel <= 137 + hold_n; rel++) begin
            @(posedge clk); #1;
            start = poke && (rel == 20);
            if (start) begin
                mode  = ~m;
                layer = 3'((l + 1) % 7);
            end
            hold = (rel > hold_k) && (rel <= hold_k + hold_n);
            @(negedge clk);
            erd = (rel <= 128 + hold_n) && !hold;
            exp_rd[rel] = erd;
            ewr = (rel > 7) ? exp_rd[rel-7] : 1'b0;
            check("rd_en", 32'(rd_en), 32'(erd));
            check("wr_en", 32'(wr_en), 32'(ewr));
            check("busy", 32'(busy), 32'((rel < 136 + hold_n) ? 1 : 0));
            check("done", 32'(done), 32'((rel == 136 + hold_n) ? 1 : 0));
            check("pe_sel", 32'(pe_sel), 32'(m));
            if (rd_en && q_rd.size() > 0) begin
                p = q_rd.pop_front();
                check("rd_addr_u", 32'(rd_addr_u), p.u);
                check("rd_addr_v", 32'(rd_addr_v), p.v);
                check("tw_idx", 32'(tw_idx), p.tw);
            end
            if (wr_en && q_wr.size() > 0) begin
                p = q_wr.pop_front();
                check("wr_addr_u", 32'(wr_addr_u), p.u);
                check("wr_addr_v", 32'(wr_addr_v), p.v);
            end
        end
        check("rd_left", q_rd.size(), 0);
        check("wr_left", q_wr.size(), 0);
        start = 1'b0;
        hold  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0; start = 1'b0; mode = 1'b0; layer = 3'd0; hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_rd_addr_u", 32'(rd_addr_u), 0);
        check("rst_tw_idx", 32'(tw_idx), 0);
        check("rst_pe_sel", 32'(pe_sel), 0);
        rst = 1'b1;

        run_layer(1'b0, 0, -1, 0, 1'b0);
        run_layer(1'b0, 6, -1, 0, 1'b0);
        run_layer(1'b1, 0, -1, 0, 1'b0);
        run_layer(1'b1, 6, -1, 0, 1'b1);
        run_layer(1'b0, 2, 10, 3, 1'b0);

        @(posedge clk); #1;
        start = 1'b1; mode = 1'b1; layer = 3'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("l7_busy", 32'(busy), 0);
            check("l7_rd_en", 32'(rd_en), 0);
        end

        @(posedge clk); #1;
        start = 1'b1; mode = 1'b1; layer = 3'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_rd_en", 32'(rd_en), 0);
        check("abort_wr_en", 32'(wr_en), 0);
        check("abort_pe_sel", 32'(pe_sel), 0);
        check("abort_rd_addr_v", 32'(rd_addr_v), 0);
        check("abort_tw_idx", 32'(tw_idx), 0);
        check("abort_wr_addr_u", 32'(wr_addr_u), 0);
        check("abort_wr_addr_v", 32'(wr_addr_v), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("post_abort_wr_en", 32'(wr_en), 0);
            check("post_abort_done", 32'(done), 0);
        end

        run_layer(1'b0, 5, -1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
